vga_timing_ctrl: RTL and testbench
==================================

// Module: vga_timing_ctrl
// PURPOSE
//  Sequences the VGA pixel datapath from the fast system clock. Produces a pixel-rate enable strobe
//  from a runtime-programmable divisor, applied only at frame boundaries. Runs the horizontal and
//  vertical raster counters and decodes sync, blanking, line and frame markers for the radar renderer.
// PARAMETERS
//  H_VISIBLE  640  visible pixels per line
//  H_FP       16   horizontal front porch, pixels
//  H_SYNC     96   hsync width, pixels
//  H_BP       48   horizontal back porch, pixels
//  V_VISIBLE  480  visible lines per frame
//  V_FP       10   vertical front porch, lines
//  V_SYNC     2    vsync width, lines
//  V_BP       33   vertical back porch, lines
//  CNT_W      10   width of the x/y counters; must hold H_TOTAL-1 and V_TOTAL-1
//  DIV_W      8    width of the divisor
//  DIV_RESET  4    divisor loaded at reset: clk_in cycles per pixel
// PORTS
//  clk_in       in   1      single system clock; all logic on posedge
//  rst_n        in   1      synchronous, active-low reset
//  div_cfg      in   DIV_W  requested divisor (clk_in cycles per pixel)
//  div_cfg_we   in   1      1-cycle write strobe for div_cfg
//  div_active   out  DIV_W  divisor currently in use
//  pix_en       out  1      1-clk_in-cycle pixel strobe; all raster logic advances on it
//  x            out  CNT_W  horizontal counter, 0..H_TOTAL-1
//  y            out  CNT_W  vertical counter, 0..V_TOTAL-1
//  video_on     out  1      1 when x<H_VISIBLE and y<V_VISIBLE
//  hsync        out  1      active-low horizontal sync
//  vsync        out  1      active-low vertical sync
//  line_start   out  1      pix_en & (x==0)
//  frame_start  out  1      pix_en & (x==0) & (y==0)
//  frame_cnt    out  16     frame counter; present only with VGA_TIMING_FRAME_CNT_EN
// BEHAVIOUR
//  - H_TOTAL=H_VISIBLE+H_FP+H_SYNC+H_BP (800). V_TOTAL likewise (525). Raster counters are x and y.
//  - Reset values: div_count=0; div_active=div_pending=DIV_RESET; pix_en=0; x=H_TOTAL-1; y=V_TOTAL-1;
//    video_on=0; hsync=1; vsync=1; frame_cnt=0.
//    The first pix_en after reset therefore lands on (0,0) and fires frame_start.
//  - Divider: div_count increments every clk_in cycle.
//    When div_count>=eff-1, div_count<=0 and pix_en<=1 for one cycle; otherwise pix_en<=0.
//    eff = (div_active<2) ? 1 : div_active. A divisor of 0 or 1 gives pix_en high every cycle.
//  - Config: div_cfg_we writes div_pending. div_active<=div_pending only in a cycle with
//    pix_en=1, x==H_TOTAL-1 and y==V_TOTAL-1 (frame wrap); div_count is cleared in that cycle.
//  - Write in the same cycle as the frame wrap: the previous div_pending is applied.
//    The new value waits for the next frame wrap.
//  - Raster: on pix_en, x increments. At H_TOTAL-1, x wraps to 0 and y increments.
//    At V_TOTAL-1 with x wrapping, y wraps to 0. Nothing changes without pix_en.
//  - video_on, hsync and vsync are registered. They are decoded from next-state x/y, so they are
//    cycle-aligned with x/y.
//  - hsync=0 for x in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC), i.e. [656,752).
//  - vsync=0 for y in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC), i.e. [490,492).
//  - line_start and frame_start are combinational from registered pix_en, x and y; no extra latency.
//  - rst_n low in any cycle, including mid-line or mid-frame: the next edge loads the reset values.
//    No partial pixel or sync pulse is completed.
//  - Divider, counters and all arithmetic are unsigned with no saturation. All counter arithmetic
//    uses CNT_W/DIV_W bits.
// CONFIGURATION
//  - VGA_TIMING_FRAME_CNT_EN defined: frame_cnt port exists. It increments by 1, modulo 2^16, in
//    each cycle where frame_start=1. Reset value is 0.
//  - Macro undefined: frame_cnt port and its logic are absent. All other behaviour is identical.
// TESTING
//  1. Release reset, no writes -> pix_en on clk_in cycles 4, 8, 12, ... after release; first
//     pix_en has x=0, y=0, frame_start=1, video_on=1.
//  2. Run one line -> line_start every 800 pix_en. hsync low for exactly 96 pix_en, first at x=656.
//     video_on low from x=640 to 799.
//  3. Run one frame -> vsync low for y=490..491 (2 lines). frame_start every 525 lines,
//     i.e. 420000 pix_en.
//  4. div_cfg=2 written mid-frame -> pix_en period stays 4 and div_active stays 4 until the frame
//     wrap, then period 2. Then write 0 -> after the next wrap pix_en is high every cycle.
//  5. div_cfg_we in the wrap cycle -> old pending value applied; the written value takes effect
//     one frame later.
//  6. rst_n=0 one cycle at x=300, y=100 -> next cycle x=799, y=524, hsync=vsync=1, video_on=0,
//     pix_en=0. With the macro defined, frame_cnt=0 after reset and 3 after three frame_start pulses.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA pixel-rate divider, raster counters and sync/blank decode.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_ctrl #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CNT_W     = 10,
    parameter int DIV_W     = 8,
    parameter int DIV_RESET = 4
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic             div_cfg_we,
    output logic [DIV_W-1:0] div_active,
    output logic             pix_en,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             video_on,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_TWO = DIV_W'(2);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_RESET);

    logic [DIV_W-1:0] r_div_count;
    logic [DIV_W-1:0] r_div_active;
    logic [DIV_W-1:0] r_div_pending;
    logic             r_pix_en;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic             r_video_on;
    logic             r_hsync;
    logic             r_vsync;

    logic [DIV_W-1:0] w_eff;
    logic             w_tick;
    logic             w_x_last;
    logic             w_y_last;
    logic             w_wrap;
    logic [CNT_W-1:0] w_x_nxt;
    logic [CNT_W-1:0] w_y_nxt;

    assign w_eff    = (r_div_active < DIV_TWO) ? DIV_ONE : r_div_active;
    assign w_tick   = r_div_count >= (w_eff - DIV_ONE);
    assign w_x_last = r_x == H_LAST;
    assign w_y_last = r_y == V_LAST;
    assign w_wrap   = r_pix_en && w_x_last && w_y_last;

    assign w_x_nxt = w_x_last ? '0 : r_x + CNT_ONE;
    assign w_y_nxt = !w_x_last ? r_y :
                     (w_y_last ? '0 : r_y + CNT_ONE);

    // Divisor swaps only at the frame wrap so no frame mixes pixel rates
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_div_count   <= '0;
            r_div_active  <= DIV_RST;
            r_div_pending <= DIV_RST;
            r_pix_en      <= 1'b0;
        end else begin
            r_pix_en <= w_tick;
            if (w_wrap || w_tick) begin
                r_div_count <= '0;
            end else begin
                r_div_count <= r_div_count + DIV_ONE;
            end
            if (w_wrap) begin
                r_div_active <= r_div_pending;
            end
            if (div_cfg_we) begin
                r_div_pending <= div_cfg;
            end
        end
    end

    // Raster moves with the strobe so each pix_en cycle shows its own pixel
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_x        <= H_LAST;
            r_y        <= V_LAST;
            r_video_on <= 1'b0;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
        end else if (w_tick) begin
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_video_on <= (w_x_nxt < H_VIS) && (w_y_nxt < V_VIS);
            r_hsync    <= !((w_x_nxt >= HS_BEG) && (w_x_nxt < HS_END));
            r_vsync    <= !((w_y_nxt >= VS_BEG) && (w_y_nxt < VS_END));
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (frame_start) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign div_active  = r_div_active;
    assign pix_en      = r_pix_en;
    assign x           = r_x;
    assign y           = r_y;
    assign video_on    = r_video_on;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign line_start  = r_pix_en && (r_x == '0);
    assign frame_start = r_pix_en && (r_x == '0) && (r_y == '0);

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: full-width lines, short frames to keep runtime low.
// Reference model tracks a linear pixel index and derives x/y/sync from it.
module tb_vga_timing_ctrl;

    localparam int HV = 640;
    localparam int HF = 16;
    localparam int HS = 96;
    localparam int HB = 48;
    localparam int VV = 2;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int CW = 10;
    localparam int DW = 8;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int TOT = HT * VT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          we = 1'b0;
    logic [DW-1:0] cfg = '0;
    logic [DW-1:0] div_active;
    logic          pix_en;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          video_on;
    logic          hsync;
    logic          vsync;
    logic          line_start;
    logic          frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0]   frame_cnt;
`endif

    always #5 clk = ~clk;

    vga_timing_ctrl #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CNT_W(CW), .DIV_W(DW), .DIV_RESET(4)
    ) u_dut (
        .clk_in(clk),
        .rst_n(rst_n),
        .div_cfg(cfg),
        .div_cfg_we(we),
        .div_active(div_active),
        .pix_en(pix_en),
        .x(x),
        .y(y),
        .video_on(video_on),
        .hsync(hsync),
        .vsync(vsync),
        .line_start(line_start),
        .frame_start(frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    int n_checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state
    int m_cnt, m_p, m_act, m_pend, m_fc;
    bit m_pe;

    // statistics gathered on pix_en cycles
    int last_pe = 0, gmin, gmax, s_pe, s_hs_low, hs_first;
    int s_vs_low, vs_first_y, s_vid_low;
    int pe_since_ls = 0, ls_gap = 0, pe_since_fs = 0, fs_gap = 0;

    task automatic model_reset();
        m_cnt = 0; m_act = 4; m_pend = 4;
        m_pe = 0; m_p = TOT - 1; m_fc = 0;
    endtask

    task automatic model_edge();
        int eff;
        bit tk, wr;
        if (!rst_n) begin
            model_reset();
        end else begin
            eff = (m_act < 2) ? 1 : m_act;
            tk = (m_cnt >= eff - 1);
            wr = m_pe && (m_p == TOT - 1);
            if (m_pe && m_p == 0) m_fc = (m_fc + 1) % 65536;
            m_cnt = (wr || tk) ? 0 : m_cnt + 1;
            if (wr) m_act = m_pend;
            if (we) m_pend = int'(cfg);
            if (tk) m_p = (m_p + 1) % TOT;
            m_pe = tk;
        end
    endtask

    task automatic check_model();
        int ex, ey;
        bit evo, ehs, evs, els, efs, bad;
        ex = m_p % HT;
        ey = m_p / HT;
        evo = (ex < HV) && (ey < VV);
        ehs = !((ex >= HV + HF) && (ex < HV + HF + HS));
        evs = !((ey >= VV + VF) && (ey < VV + VF + VS));
        els = m_pe && (ex == 0);
        efs = m_pe && (m_p == 0);
        bad = (pix_en !== m_pe) || (x !== CW'(ex)) || (y !== CW'(ey)) ||
              (video_on !== evo) || (hsync !== ehs) || (vsync !== evs) ||
              (line_start !== els) || (frame_start !== efs) ||
              (div_active !== DW'(m_act));
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (frame_cnt !== 16'(m_fc)) bad = 1'b1;
`endif
        n_checks++;
        if (bad) begin
            errors++;
            if (errors <= 20)
                $display("FAIL model cyc=%0d got pe=%0b x=%0d y=%0d vo=%0b hs=%0b vs=%0b ls=%0b fs=%0b act=%0d want pe=%0b x=%0d y=%0d vo=%0b hs=%0b vs=%0b ls=%0b fs=%0b act=%0d",
                         cyc, pix_en, x, y, video_on, hsync, vsync, line_start,
                         frame_start, div_active, m_pe, ex, ey, evo, ehs, evs,
                         els, efs, m_act);
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic clr_stats();
        gmin = 1000000; gmax = 0; s_pe = 0; s_hs_low = 0; hs_first = -1;
        s_vs_low = 0; vs_first_y = -1; s_vid_low = 0;
    endtask

    task automatic tick();
        int gap;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check_model();
        if (pix_en === 1'b1) begin
            gap = cyc - last_pe;
            last_pe = cyc;
            if (gap < gmin) gmin = gap;
            if (gap > gmax) gmax = gap;
            s_pe++;
            pe_since_ls++;
            pe_since_fs++;
            if (!hsync) begin
                s_hs_low++;
                if (hs_first < 0) hs_first = int'(x);
            end
            if (!vsync) begin
                s_vs_low++;
                if (vs_first_y < 0) vs_first_y = int'(y);
            end
            if (!video_on) s_vid_low++;
            if (line_start) begin ls_gap = pe_since_ls; pe_since_ls = 0; end
            if (frame_start) begin fs_gap = pe_since_fs; pe_since_fs = 0; end
        end
    endtask

    task automatic wait_pix(input int xx, input int yy, input int budget,
                            input string name);
        int n = 0;
        while (!(pix_en === 1'b1 && int'(x) == xx && int'(y) == yy) &&
               n < budget) begin
            tick();
            n++;
        end
        if (!(pix_en === 1'b1 && int'(x) == xx && int'(y) == yy)) begin
            n_checks++;
            errors++;
            $display("FAIL %s: timeout at x=%0d y=%0d want x=%0d y=%0d",
                     name, x, y, xx, yy);
        end
    endtask

    typedef struct {
        int cyc;
        bit we;
        int cfg;
        bit pe;
        int x;
        int y;
        bit ls;
        bit fs;
        bit vo;
        bit hs;
        bit vs;
        int act;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int c;
        tbl[0] = '{1,  0, 0, 0, HT-1, VT-1, 0, 0, 0, 1, 1, 4};
        tbl[1] = '{3,  0, 0, 0, HT-1, VT-1, 0, 0, 0, 1, 1, 4};
        tbl[2] = '{4,  0, 0, 1, 0,    0,    1, 1, 1, 1, 1, 4};
        tbl[3] = '{5,  1, 9, 0, 0,    0,    0, 0, 1, 1, 1, 4};
        tbl[4] = '{8,  0, 0, 1, 1,    0,    0, 0, 1, 1, 1, 4};
        tbl[5] = '{12, 0, 0, 1, 2,    0,    0, 0, 1, 1, 1, 4};
        tbl[6] = '{13, 0, 0, 0, 2,    0,    0, 0, 1, 1, 1, 4};

        model_reset();
        clr_stats();
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset x", int'(x), HT - 1);
        chk("reset y", int'(y), VT - 1);
        chk("reset pix_en", int'(pix_en), 0);
        rst_n = 1'b1;

        // startup vectors, cycles counted from reset release
        c = 0;
        for (int i = 0; i < 7; i++) begin
            while (c < tbl[i].cyc) begin
                tick();
                c++;
                we = 1'b0;
            end
            chk($sformatf("vec%0d.pe", i), int'(pix_en), int'(tbl[i].pe));
            chk($sformatf("vec%0d.x", i), int'(x), tbl[i].x);
            chk($sformatf("vec%0d.y", i), int'(y), tbl[i].y);
            chk($sformatf("vec%0d.ls", i), int'(line_start), int'(tbl[i].ls));
            chk($sformatf("vec%0d.fs", i), int'(frame_start), int'(tbl[i].fs));
            chk($sformatf("vec%0d.vo", i), int'(video_on), int'(tbl[i].vo));
            chk($sformatf("vec%0d.hs", i), int'(hsync), int'(tbl[i].hs));
            chk($sformatf("vec%0d.vs", i), int'(vsync), int'(tbl[i].vs));
            chk($sformatf("vec%0d.act", i), int'(div_active), tbl[i].act);
            we = tbl[i].we;
            cfg = DW'(tbl[i].cfg);
        end
        tick();
        we = 1'b0;

        // one full line
        wait_pix(0, 1, 4000, "line1 start");
        clr_stats();
        wait_pix(HT - 1, 1, 4000, "line1 end");
        chk("hsync low pixels", s_hs_low, 96);
        chk("hsync first x", hs_first, 656);
        chk("video low pixels", s_vid_low, 160);
        chk("line pixels", s_pe, 799);
        wait_pix(0, 2, 10, "line2 start");
        chk("line_start gap", ls_gap, 800);

        // mid-line reset
        wait_pix(300, 2, 4000, "x300");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst x", int'(x), HT - 1);
        chk("rst y", int'(y), VT - 1);
        chk("rst hsync", int'(hsync), 1);
        chk("rst vsync", int'(vsync), 1);
        chk("rst video_on", int'(video_on), 0);
        chk("rst pix_en", int'(pix_en), 0);
        chk("rst div_active", int'(div_active), 4);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("rst frame_cnt", int'(frame_cnt), 0);
`endif

        // divisor 2 written mid-frame
        wait_pix(0, 1, 5000, "f1 y1");
        clr_stats();
        we = 1'b1;
        cfg = 8'd2;
        tick();
        we = 1'b0;
        wait_pix(HT - 1, VT - 1, 25000, "wrap1");
        chk("f1 gap min", gmin, 4);
        chk("f1 gap max", gmax, 4);
        chk("vsync low pixels", s_vs_low, 2 * HT);
        chk("vsync first y", vs_first_y, VV + VF);
        chk("act before wrap1", int'(div_active), 4);
        tick();
        chk("act after wrap1", int'(div_active), 2);
        wait_pix(0, 0, 10, "f2 start");
        chk("f2 frame_start", int'(frame_start), 1);
        chk("frame_start gap", fs_gap, TOT);
        clr_stats();
        wait_pix(10, 0, 100, "f2 x10");
        chk("f2 gap min", gmin, 2);
        chk("f2 gap max", gmax, 2);

        // divisor 0: strobe every cycle after the wrap
        wait_pix(0, 1, 5000, "f2 y1");
        we = 1'b1;
        cfg = 8'd0;
        tick();
        we = 1'b0;
        wait_pix(HT - 1, VT - 1, 12000, "wrap2");
        chk("act before wrap2", int'(div_active), 2);
        tick();
        chk("act after wrap2", int'(div_active), 0);
        wait_pix(0, 0, 10, "f3 start");
        tick();
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("frame_cnt after 3", int'(frame_cnt), 3);
`endif
        clr_stats();
        repeat (20) tick();
        chk("div0 pixels in 20", s_pe, 20);

        // write landing in the wrap cycle waits one more frame
        wait_pix(HT - 1, VT - 1, 6000, "wrap3");
        we = 1'b1;
        cfg = 8'd2;
        tick();
        we = 1'b0;
        chk("act after wrap3", int'(div_active), 0);
        wait_pix(HT - 1, VT - 1, 6000, "wrap4");
        chk("act before wrap4", int'(div_active), 0);
        tick();
        chk("act after wrap4", int'(div_active), 2);
        wait_pix(0, 0, 10, "f5 start");
        clr_stats();
        wait_pix(5, 0, 100, "f5 x5");
        chk("f5 gap min", gmin, 2);
        chk("f5 gap max", gmax, 2);

        // random writes and occasional resets against the model
        repeat (8000) begin
            we = ($urandom_range(0, 7) == 0);
            cfg = DW'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 2999) != 0);
            tick();
        end
        rst_n = 1'b1;
        we = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, errors);
        $finish;
    end

endmodule
